// File: rtl/df_multiplier_seq.sv
// Sequential shift-add coefficient multiplier with valid/ready handshake: one coefficient
// bit per cycle (LSB first), then optional round-half-up and a saturating output slice.
module df_multiplier_seq #(
  parameter int COEF_W    = 5,
  parameter int DATA_W    = 8,
  parameter int OUT_SHIFT = 8,
  parameter int OUT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] coef,
  input  logic [DATA_W-1:0] data,
  input  logic              round_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat
);

  localparam int CNT_W = $clog2(COEF_W + 1);
  localparam int PW    = COEF_W + DATA_W;
  // One spare bit so the rounding carry out of the top of the slice is kept
  localparam int TW    = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [COEF_W-1:0]   r_coef_sr;
  logic [DATA_W-1:0]   r_data;
  logic                r_round;
  logic [PW-1:0]       r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [OUT_W-1:0]    r_out_data;
  logic                r_out_sat;

  logic                w_accept;
  logic                w_last;
  logic [PW-1:0]       w_addend;
  logic [PW-1:0]       w_sum;
  logic [TW-1:0]       w_p_ext;
  logic [TW-1:0]       w_rnd;
  logic [TW-1:0]       w_t;
  logic                w_sat;
  logic [OUT_W-1:0]    w_trunc;
  logic [OUT_W-1:0]    w_out_data;

  assign in_ready  = rst_n && (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == CNT_W'(COEF_W - 1));

  assign w_addend = {{COEF_W{1'b0}}, r_data} << r_cnt;
  assign w_sum    = r_coef_sr[0] ? (r_acc + w_addend) : r_acc;

  // w_sum on the last BUSY cycle is the complete product
  assign w_p_ext = {1'b0, w_sum};

  generate
    if (OUT_SHIFT > 0) begin : g_round
      assign w_rnd = {{(TW-1){1'b0}}, r_round & w_sum[OUT_SHIFT-1]};
    end else begin : g_no_round
      assign w_rnd = '0;
    end
  endgenerate

  assign w_t = (w_p_ext >> OUT_SHIFT) + w_rnd;

  generate
    if (OUT_W < TW) begin : g_sat
      assign w_sat   = |w_t[TW-1:OUT_W];
      assign w_trunc = w_t[OUT_W-1:0];
    end else begin : g_no_sat
      assign w_sat   = 1'b0;
      assign w_trunc = OUT_W'(w_t);
    end
  endgenerate

  assign w_out_data = w_sat ? {OUT_W{1'b1}} : w_trunc;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_coef_sr  <= '0;
      r_data     <= '0;
      r_round    <= 1'b0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_coef_sr <= coef;
            r_data    <= data;
            r_round   <= round_en;
            r_acc     <= '0;
            r_cnt     <= '0;
          end
        end
        S_BUSY: begin
          r_acc     <= w_sum;
          r_coef_sr <= r_coef_sr >> 1;
          r_cnt     <= r_cnt + 1'b1;
          if (w_last) begin
            r_out_data <= w_out_data;
            r_out_sat  <= w_sat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_df_multiplier_seq.sv
// Directed bench for df_multiplier_seq: a default instance and an OUT_W=4 instance share
// the same stimulus so each vector checks both the plain and the saturating slice.
module tb_df_multiplier_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [4:0] coef;
  logic [7:0] data;
  logic       round_en;
  logic       out_ready;

  logic       in_ready, out_valid, out_sat;
  logic [7:0] out_data;
  logic       in_ready4, out_valid4, out_sat4;
  logic [3:0] out_data4;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int hs_cnt = 0;

  df_multiplier_seq u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .coef(coef), .data(data), .round_en(round_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  df_multiplier_seq #(.OUT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .coef(coef), .data(data), .round_en(round_en),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_sat(out_sat4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end

  typedef struct {
    logic [4:0] coef;
    logic [7:0] data;
    logic       rnd;
    logic [7:0] exp8;
    logic       sat8;
    logic [3:0] exp4;
    logic       sat4;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Caller is at a negedge with both instances idle; returns at a negedge, idle again.
  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    coef = v.coef; data = v.data; round_en = v.rnd;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    coef = ~v.coef; data = ~v.data; round_en = ~v.rnd;
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk({tag, ".busy_rdy"}, {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, lat, 32'd5);
    chk({tag, ".out_data"}, {24'd0, out_data}, {24'd0, v.exp8});
    chk({tag, ".out_sat"}, {31'd0, out_sat}, {31'd0, v.sat8});
    chk({tag, ".out_valid4"}, {31'd0, out_valid4}, 32'd1);
    chk({tag, ".out_data4"}, {28'd0, out_data4}, {28'd0, v.exp4});
    chk({tag, ".out_sat4"}, {31'd0, out_sat4}, {31'd0, v.sat4});
    @(negedge clk);
    chk({tag, ".out_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat, hs0, t1, t2, seen;

    //          coef   data    rnd   exp8   sat8  exp4   sat4
    vecs[0] = '{5'd31, 8'd255, 1'b0, 8'd30, 1'b0, 4'd15, 1'b1}; // P=0x1EE1
    vecs[1] = '{5'd31, 8'd255, 1'b1, 8'd31, 1'b0, 4'd15, 1'b1}; // P[7]=1 rounds up
    vecs[2] = '{5'd5,  8'd100, 1'b1, 8'd2,  1'b0, 4'd2,  1'b0}; // P=500=0x1F4
    vecs[3] = '{5'd3,  8'd200, 1'b0, 8'd2,  1'b0, 4'd2,  1'b0}; // P=600=0x258
    vecs[4] = '{5'd0,  8'd255, 1'b0, 8'd0,  1'b0, 4'd0,  1'b0};
    vecs[5] = '{5'd31, 8'd0,   1'b1, 8'd0,  1'b0, 4'd0,  1'b0};
    vecs[6] = '{5'd17, 8'd129, 1'b0, 8'd8,  1'b0, 4'd8,  1'b0}; // P=2193=0x891
    vecs[7] = '{5'd17, 8'd129, 1'b1, 8'd9,  1'b0, 4'd9,  1'b0};
    vecs[8] = '{5'd20, 8'd13,  1'b1, 8'd1,  1'b0, 4'd1,  1'b0}; // P=260, P[7]=0

    rst_n = 1'b0; in_valid = 1'b0; coef = '0; data = '0; round_en = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.out_data", {24'd0, out_data}, 32'd0);
    chk("rst.out_sat", {31'd0, out_sat}, 32'd0);
    chk("rst.out_sat4", {31'd0, out_sat4}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Backpressure with stray in_valid pulses in BUSY and DONE
    hs0 = hs_cnt;
    coef = 5'd31; data = 8'd255; round_en = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    lat = 0; seen = 0;
    while (!out_valid && lat < 20) begin
      in_valid = lat[0];
      coef = 5'd7; data = 8'd3; round_en = 1'b1;
      seen |= int'(in_ready);
      @(negedge clk);
      lat++;
    end
    chk("bp.latency", lat, 32'd5);
    chk("bp.busy_in_ready", seen, 32'd0);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      coef = 5'(k + 1); data = 8'(k * 40);
      chk($sformatf("bp.hold_valid%0d", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp.hold_data%0d", k), {24'd0, out_data}, 32'd30);
      chk($sformatf("bp.hold_rdy%0d", k), {31'd0, in_ready}, 32'd0);
      if (k == 3) begin
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
      @(negedge clk);
    end
    chk("bp.valid_drop", {31'd0, out_valid}, 32'd0);
    chk("bp.in_ready_back", {31'd0, in_ready}, 32'd1);
    repeat (10) @(negedge clk);
    chk("bp.no_extra_result", {31'd0, out_valid}, 32'd0);
    chk("bp.handshakes", hs_cnt - hs0, 32'd1);

    // Back-to-back accepts with in_valid held high
    coef = 5'd31; data = 8'd255; round_en = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    lat = 0;
    while (!out_valid && lat < 30) begin @(negedge clk); lat++; end
    t1 = cyc;
    chk("b2b.first_data", {24'd0, out_data}, 32'd30);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 30) begin @(negedge clk); lat++; end
    t2 = cyc;
    in_valid = 1'b0;
    chk("b2b.spacing", t2 - t1, 32'd7);
    chk("b2b.second_data", {24'd0, out_data}, 32'd30);
    @(negedge clk);
    chk("b2b.idle", {31'd0, in_ready}, 32'd1);

    // Reset on the third BUSY cycle aborts the operation
    hs0 = hs_cnt;
    coef = 5'd31; data = 8'd255; round_en = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort.out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort.out_data", {24'd0, out_data}, 32'd0);
    chk("abort.out_sat", {31'd0, out_sat}, 32'd0);
    chk("abort.in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort.out_data4", {28'd0, out_data4}, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen |= int'(out_valid);
    end
    chk("abort.no_result", seen, 32'd0);
    chk("abort.handshakes", hs_cnt - hs0, 32'd0);
    run_vec("post_rst", vecs[6]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
